// File: rtl/rv32_timer_target_if.sv
// Data-bus view of the machine timer: address/strobe/data in,
// select/read-data/fault back, all resolved in one cycle.
interface rv32_timer_target_if;
  logic [31:0] address_in;
  logic        read_in;
  logic        write_in;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic        select_out;
  logic [31:0] read_value_out;
  logic        fault_out;

  modport master (
    output address_in, read_in, write_in,
    output write_mask_in, write_value_in,
    input  select_out, read_value_out, fault_out
  );

  modport slave (
    input  address_in, read_in, write_in,
    input  write_mask_in, write_value_in,
    output select_out, read_value_out, fault_out
  );
endinterface

// File: rtl/rv32_timer_target.sv
// Memory-mapped RISC-V machine timer (mtime/mtimecmp, optional msip).
// Define RV32_TIMER_MSIP_EN to map msip at offset 0x10.
module rv32_timer_target #(
  parameter logic [31:0] BASE_ADDR = 32'h0002_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic clk,
  input  logic reset,
  rv32_timer_target_if.slave bus,
`ifdef RV32_TIMER_MSIP_EN
  output logic soft_interrupt_out,
`endif
  output logic timer_interrupt_out
);

  localparam int unsigned PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;
  logic          tick;
  logic [63:0]   mtime;
  logic [63:0]   mtime_nxt;
  logic [63:0]   mtimecmp;
  logic [4:0]    off;
  logic [2:0]    word;
  logic          hit;
  logic          legal;
  logic          fault;
  logic          wr_en;
  logic          wr_tlo;
  logic          wr_thi;
  logic [31:0]   rdata;
`ifdef RV32_TIMER_MSIP_EN
  logic          msip;
`endif

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] val,
    input logic [3:0]  m
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[8*b +: 8] = val[8*b +: 8];
    return r;
  endfunction

  assign off  = bus.address_in[4:0];
  assign word = off[4:2];
  assign hit  = bus.address_in[31:5] == BASE_ADDR[31:5];
  assign tick = pcnt == PLAST;

  always_comb begin
    legal = 1'b0;
    if (off[1:0] == 2'b00) begin
      unique case (word)
        3'd0, 3'd1, 3'd2, 3'd3: legal = 1'b1;
`ifdef RV32_TIMER_MSIP_EN
        3'd4:    legal = 1'b1;
`endif
        default: legal = 1'b0;
      endcase
    end
  end

  assign fault = hit && (bus.read_in || bus.write_in) && !legal;
  assign wr_en = hit && bus.write_in && !fault;

  // An empty mask is a no-op and must not steal a tick.
  assign wr_tlo = wr_en && word == 3'd0 && |bus.write_mask_in;
  assign wr_thi = wr_en && word == 3'd1 && |bus.write_mask_in;

  always_comb begin
    rdata = '0;
    unique case (word)
      3'd0:    rdata = mtime[31:0];
      3'd1:    rdata = mtime[63:32];
      3'd2:    rdata = mtimecmp[31:0];
      3'd3:    rdata = mtimecmp[63:32];
`ifdef RV32_TIMER_MSIP_EN
      3'd4:    rdata = {31'b0, msip};
`endif
      default: rdata = '0;
    endcase
  end

  assign bus.select_out     = hit;
  assign bus.fault_out      = fault;
  assign bus.read_value_out =
    (hit && bus.read_in && !fault) ? rdata : '0;

  always_comb begin
    mtime_nxt = mtime;
    if (wr_tlo || wr_thi) begin
      if (wr_tlo)
        mtime_nxt[31:0] = merge(mtime[31:0],
          bus.write_value_in, bus.write_mask_in);
      if (wr_thi)
        mtime_nxt[63:32] = merge(mtime[63:32],
          bus.write_value_in, bus.write_mask_in);
    end else if (tick) begin
      mtime_nxt = mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt                <= '0;
      mtime               <= '0;
      mtimecmp            <= '1;
      timer_interrupt_out <= 1'b0;
    end else begin
      pcnt                <= tick ? '0 : pcnt + 1'b1;
      mtime               <= mtime_nxt;
      timer_interrupt_out <= mtime >= mtimecmp;
      if (wr_en && word == 3'd2)
        mtimecmp[31:0] <= merge(mtimecmp[31:0],
          bus.write_value_in, bus.write_mask_in);
      if (wr_en && word == 3'd3)
        mtimecmp[63:32] <= merge(mtimecmp[63:32],
          bus.write_value_in, bus.write_mask_in);
    end
  end

`ifdef RV32_TIMER_MSIP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      msip <= 1'b0;
    else if (wr_en && word == 3'd4 && bus.write_mask_in[0])
      msip <= bus.write_value_in[0];
  end

  assign soft_interrupt_out = msip;
`endif

endmodule

// File: doc/rv32_timer_target.md
# rv32_timer_target

Memory-mapped machine timer that answers the core's data memory bus as a single-cycle responder. It holds a 64-bit `mtime` counter and a 64-bit `mtimecmp` compare register, and raises the machine timer interrupt when `mtime >= mtimecmp`. It sits on the data bus interconnect beside the RAM, decoding its own 32-byte window and returning read data and faults in the same cycle the memory stage presents the access.

## Interface
- `BASE_ADDR`, default `32'h0002_0000`: window base; bits [4:0] must be zero.
- `PRESCALE`, default `1`: `clk` cycles per `mtime` increment; must be ≥1.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `address_in` input 32: byte address from the data bus.
- `read_in` input 1: read request this cycle.
- `write_in` input 1: write request this cycle.
- `write_mask_in` input 4: byte enables; bit n enables bits [8n+7:8n].
- `write_value_in` input 32: write data, byte-lane aligned.
- `select_out` output 1: address is inside `[BASE_ADDR, BASE_ADDR+0x1F]`.
- `read_value_out` output 32: read data, combinational.
- `fault_out` output 1: access error, combinational.
- `timer_interrupt_out` output 1: registered machine timer interrupt.

## Operation
- Register map (offset = `address_in[4:0]`, word-aligned):
  - 0x00 `mtime[31:0]`
  - 0x04 `mtime[63:32]`
  - 0x08 `mtimecmp[31:0]`
  - 0x0C `mtimecmp[63:32]`
  - 0x10 `msip`; only when the macro in Configuration is defined.
- `select_out = address_in[31:5] == BASE_ADDR[31:5]`. This is independent of `read_in`/`write_in`.
- `fault_out = select_out && (read_in || write_in) && (offset undefined || address_in[1:0] != 0)`. A faulting access neither writes nor returns data; `read_value_out` is 0.
- Read: `read_value_out` is the selected word of the current register state when `select_out && read_in && !fault_out`. Otherwise it is 0.
- Write: applies at the clock edge when `select_out && write_in && !fault_out`. Each enabled byte is replaced; disabled bytes keep their value. `write_mask_in == 0` is a legal no-op.
- `read_in` and `write_in` together: the write is performed, and read data shows the pre-write value.
- Prescaler:
  - `ceil(log2(PRESCALE))`-bit counter counting 0..PRESCALE-1, then wrapping to 0.
  - A tick is issued on the cycle the counter equals PRESCALE-1. When `PRESCALE == 1`, every cycle ticks.
- `mtime` increments by 1 on a tick, with 64-bit arithmetic; `0xFFFF_FFFF_FFFF_FFFF` wraps to 0. The carry from the low word into the high word lands in the same edge.
- A write to either `mtime` word in a tick cycle takes precedence: the whole 64-bit increment is suppressed that cycle. The prescaler is never reset by bus writes.
- Interrupt: `timer_interrupt_out <= (mtime >= mtimecmp)` as an unsigned 64-bit compare of the register values before the edge.

## Timing
- Reset (`reset` low, asynchronous):
  - `mtime = 0`
  - `mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF`
  - prescaler = 0
  - `timer_interrupt_out = 0`
  - `msip = 0`
- Release is taken on the first rising edge with `reset` high.
- Combinational outputs (`select_out`, `read_value_out`, `fault_out`) follow the inputs with zero cycles of latency. They are not gated by reset.
- Write data is visible on reads from the cycle after the write edge.
- Interrupt latency:
  - The cycle after the edge where `mtime` first reaches `mtimecmp`, the interrupt is asserted.
  - A `mtimecmp` write raising it above `mtime` deasserts the interrupt one cycle after the write edge.
- The high and low words of a 64-bit register are not updated atomically across two bus writes. Software writes `mtimecmp` high=0xFFFF_FFFF first.
- Reset asserted mid-count clears all state immediately; no pending tick survives.

## Configuration
- `RV32_TIMER_MSIP_EN` defined:
  - Offset 0x10 maps `msip`. Only bit 0 is writable (byte lane 0); bits [31:1] read 0.
  - Adds port `soft_interrupt_out` output 1, driven directly from `msip[0]` with reset value 0.
- Not defined:
  - Offset 0x10 faults like any undefined offset.
  - The `msip` register and the `soft_interrupt_out` port do not exist.

## Test plan
- After reset release, read 0x00 and 0x0C with `PRESCALE=1` → `mtime` low is 0; `mtimecmp` high is `0xFFFF_FFFF`; `timer_interrupt_out=0`; the first read after N idle cycles returns N.
- Write `mtimecmp` = {0, 20}, then let `mtime` count from 0 → `timer_interrupt_out` rises the cycle after `mtime==20`. Writing `mtimecmp` low = 100 → the interrupt falls one cycle later.
- Write `mtime` = {0, 0xFFFF_FFFF} in a tick cycle, then idle one tick → reads give low=0, high=1. A write coinciding with a tick shows the written value, not +1.
- Byte write of 0xAB with mask 4'b0100 to 0x08, starting from `mtimecmp` low = 0 → readback 0x00AB_0000.
- Read at BASE+0x14, write at BASE+0x02, and read at BASE+0x40 → `fault_out=1`, `select_out=1`, and data 0 for the first two; the third gives `select_out=0` and `fault_out=0`. No register changes.
- With `PRESCALE=4` → `mtime` increments once every 4 cycles. Assert `reset` low mid-count → all registers return to their reset values immediately.
